// File: rtl/uart_pkg.sv
// Shared types and default sizing for the UART receive buffer.
package uart_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        FIRED
    } timeout_state_t;

    localparam int UART_FIFO_DEPTH  = 16;
    localparam int UART_FIFO_THRESH = 8;

endpackage

// File: rtl/sync_fifo.sv
// Generic first-word-fall-through FIFO with wrap-bit pointers for full/empty/level.
// Latency: a write is visible on rd_dat the next cycle; rd_dat is read combinationally from the head slot.
// Backpressure: a write is refused while full unless a read frees the head slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr,
    input  logic [WIDTH-1:0]       wr_dat,
    input  logic                   rd,
    output logic [WIDTH-1:0]       rd_dat,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_INC = (AW + 1)'(1);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr_acc;
    logic             rd_acc;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign level = wr_ptr_q - rd_ptr_q;

    // When full, a same-cycle read makes room: the write lands in the slot being vacated.
    assign wr_acc = wr & (~full | rd);
    assign rd_acc = rd & ~empty;

    assign rd_dat = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_INC;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_INC;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_dat;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: FWFT FIFO plus sticky overrun, threshold irq and (with UART_RX_FIFO_TIMEOUT_EN) an idle-timeout flag.
// Latency: byte readable one cycle after its write strobe; o_irq level term lags o_level by one cycle.
// Backpressure: none toward the receiver; a byte arriving while full with no pop is dropped and flagged.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH   = UART_FIFO_DEPTH,
    parameter int THRESH  = UART_FIFO_THRESH,
    parameter int TIMEOUT = 4096
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_wr,
    input  logic [7:0]             i_wr_data,
    input  logic                   i_rd,
    output logic [7:0]             o_rd_data,
    output logic                   o_empty,
    output logic                   o_full,
    output logic [$clog2(DEPTH):0] o_level,
    output logic                   o_overrun,
    input  logic                   i_clr_overrun,
    output logic                   o_irq,
    output logic                   o_timeout
);

    localparam int LW = $clog2(DEPTH) + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_rx_fifo: DEPTH must be a power of two >= 2");
    end
    if (THRESH < 1 || THRESH > DEPTH) begin : g_bad_thresh
        $error("uart_rx_fifo: THRESH must be in 1..DEPTH");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("uart_rx_fifo: TIMEOUT must be >= 2");
    end

    byte_t           fifo_dat;
    logic            fifo_empty;
    logic            fifo_full;
    logic [LW-1:0]   fifo_level;
    logic            ovr_q, ovr_d;
    logic            irq_q, irq_d;
    logic            timeout;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (i_clk),
        .rst    (i_reset),
        .wr     (i_wr),
        .wr_dat (i_wr_data),
        .rd     (i_rd),
        .rd_dat (fifo_dat),
        .empty  (fifo_empty),
        .full   (fifo_full),
        .level  (fifo_level)
    );

    always_comb begin
        ovr_d = ovr_q;
        if (i_clr_overrun) begin
            ovr_d = 1'b0;
        end
        // Set is evaluated last so a drop in the same cycle as a clear is not lost.
        if (i_wr & fifo_full & ~i_rd) begin
            ovr_d = 1'b1;
        end
        irq_d = (fifo_level >= LW'(THRESH));
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            ovr_q <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            ovr_q <= ovr_d;
            irq_q <= irq_d;
        end
    end

`ifdef UART_RX_FIFO_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_INC  = CW'(1);

    timeout_state_t state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           wr_acc;
    logic           rd_acc;
    logic           empty_nxt;

    assign wr_acc = i_wr & (~fifo_full | i_rd);
    assign rd_acc = i_rd & ~fifo_empty;
    // Looks one edge ahead so o_timeout drops the cycle after the last byte is popped.
    assign empty_nxt = ~wr_acc & (fifo_empty | (rd_acc & (fifo_level == LW'(1))));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (empty_nxt) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (wr_acc) begin
            state_d = COUNT;
            cnt_d   = '0;
        end else if (state_q == COUNT) begin
            if (cnt_q == CNT_LAST) begin
                state_d = FIRED;
            end else begin
                cnt_d = cnt_q + CNT_INC;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign timeout = (state_q == FIRED);
`else
    assign timeout = 1'b0;
`endif

    assign o_rd_data = fifo_dat;
    assign o_empty   = fifo_empty;
    assign o_full    = fifo_full;
    assign o_level   = fifo_level;
    assign o_overrun = ovr_q;
    assign o_irq     = irq_q | timeout;
    assign o_timeout = timeout;

endmodule
